rv32im_decode_execute: RTL and testbench

//  Decode/execute slice of the RV32IM 5-stage pipeline: main decoder (control),
//  32-bit integer/M-extension ALU and branch/jump resolver in one block.

---
 rtl/rv32im_decode_execute.sv | 219 +++++++++++++++++++++
 tb/tb_rv32im_decode_execute.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_decode_execute.sv
// Decode/execute slice of the RV32IM pipeline: main decoder, integer/M ALU and
// branch/jump resolver, with all results registered toward EX/MEM and the PC-select mux.
module rv32im_decode_execute (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EN,
    input  logic [31:0] INSTRUCTION,
    input  logic [31:0] PC,
    input  logic [31:0] REG_DATA1,
    input  logic [31:0] REG_DATA2,
    input  logic [31:0] IMMEDIATE,
    output logic [2:0]  IMMEDIATE_SELECT,
    output logic [31:0] ALU_OUT,
    output logic        BJ_SIG,
    output logic        REG_WRITE_EN,
    output logic [4:0]  REG_WRITE_ADDR,
    output logic [3:0]  DATA_MEM_READ,
    output logic [2:0]  DATA_MEM_WRITE,
    output logic [1:0]  WB_VALUE_SELECT,
    output logic [31:0] STORE_DATA
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned MULW = 2 * XLEN + 2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WB_PC  = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SLL    = 5'b00001;
    localparam logic [4:0] ALU_SLT    = 5'b00010;
    localparam logic [4:0] ALU_SLTU   = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SRL    = 5'b00101;
    localparam logic [4:0] ALU_OR     = 5'b00110;
    localparam logic [4:0] ALU_AND    = 5'b00111;
    localparam logic [4:0] ALU_MUL    = 5'b01000;
    localparam logic [4:0] ALU_MULH   = 5'b01001;
    localparam logic [4:0] ALU_MULHSU = 5'b01010;
    localparam logic [4:0] ALU_MULHU  = 5'b01011;
    localparam logic [4:0] ALU_DIV    = 5'b01100;
    localparam logic [4:0] ALU_DIVU   = 5'b01101;
    localparam logic [4:0] ALU_REM    = 5'b01110;
    localparam logic [4:0] ALU_REMU   = 5'b01111;
    localparam logic [4:0] ALU_SUB    = 5'b10000;
    localparam logic [4:0] ALU_SRA    = 5'b10101;
    localparam logic [4:0] ALU_FWD    = 5'b11111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = INSTRUCTION[6:0];
    assign funct3 = INSTRUCTION[14:12];
    assign funct7 = INSTRUCTION[31:25];

    logic [2:0] imm_sel;
    logic       op1_pc, op2_imm, reg_we, is_jump, is_jalr, is_branch;
    logic [4:0] alu_op;
    logic [1:0] wb_sel;
    logic [3:0] mem_rd;
    logic [2:0] mem_wr;

    // Main decoder; unknown opcodes fall through as a bubble
    always_comb begin : decode
        imm_sel   = IMM_I;
        op1_pc    = 1'b0;
        op2_imm   = 1'b1;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        wb_sel    = WB_PC;
        mem_rd    = 4'b0000;
        mem_wr    = 3'b000;
        is_jump   = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OPC_LUI:    begin imm_sel = IMM_U; alu_op = ALU_FWD; reg_we = 1'b1; wb_sel = WB_ALU; end
            OPC_AUIPC:  begin imm_sel = IMM_U; op1_pc = 1'b1; reg_we = 1'b1; wb_sel = WB_ALU; end
            OPC_JAL:    begin imm_sel = IMM_J; op1_pc = 1'b1; reg_we = 1'b1; is_jump = 1'b1; end
            OPC_JALR:   begin reg_we = 1'b1; is_jump = 1'b1; is_jalr = 1'b1; end
            OPC_BRANCH: begin imm_sel = IMM_B; op1_pc = 1'b1; is_branch = 1'b1; end
            OPC_LOAD:   begin reg_we = 1'b1; wb_sel = WB_MEM; mem_rd = {1'b1, funct3}; end
            OPC_STORE:  begin imm_sel = IMM_S; mem_wr = {1'b1, funct3[1:0]}; end
            OPC_OPIMM: begin
                reg_we = 1'b1;
                wb_sel = WB_ALU;
                alu_op = (funct3 == 3'b101 && funct7[5]) ? ALU_SRA : {2'b00, funct3};
            end
            OPC_OP: begin
                op2_imm = 1'b0;
                reg_we  = 1'b1;
                wb_sel  = WB_ALU;
                if (funct7 == 7'b0000001)
                    alu_op = {2'b01, funct3};
                else if (funct7[5])
                    alu_op = (funct3 == 3'b101) ? ALU_SRA : ALU_SUB;
                else
                    alu_op = {2'b00, funct3};
            end
            default: ;
        endcase
    end

    assign IMMEDIATE_SELECT = imm_sel;

    logic [XLEN-1:0] op_a, op_b;
    logic [4:0]      shamt;
    assign op_a  = op1_pc ? PC : REG_DATA1;
    assign op_b  = op2_imm ? IMMEDIATE : REG_DATA2;
    assign shamt = op_b[4:0];

    // Operands extended to 33 bits so one signed multiplier covers all MULH variants
    logic              a_signed, b_signed;
    logic signed [MULW-1:0] mul_a, mul_b, mul_p;
    assign a_signed = (alu_op != ALU_MULHU);
    assign b_signed = (alu_op == ALU_MUL) || (alu_op == ALU_MULH);
    assign mul_a    = {{(XLEN + 2){op_a[XLEN-1] & a_signed}}, op_a};
    assign mul_b    = {{(XLEN + 2){op_b[XLEN-1] & b_signed}}, op_b};
    assign mul_p    = mul_a * mul_b;

    // Signed division through magnitudes keeps INT_MIN / -1 well defined
    logic            b_zero;
    logic [XLEN-1:0] a_mag, b_mag, bs_mag, bu_safe, qs_mag, rs_mag, div_s, rem_s, div_u, rem_u;
    assign b_zero  = (op_b == '0);
    assign a_mag   = op_a[XLEN-1] ? -op_a : op_a;
    assign b_mag   = op_b[XLEN-1] ? -op_b : op_b;
    assign bs_mag  = b_zero ? XLEN'(1) : b_mag;
    assign bu_safe = b_zero ? XLEN'(1) : op_b;
    assign qs_mag  = a_mag / bs_mag;
    assign rs_mag  = a_mag % bs_mag;
    assign div_s   = b_zero ? '1 : ((op_a[XLEN-1] ^ op_b[XLEN-1]) ? -qs_mag : qs_mag);
    assign rem_s   = b_zero ? op_a : (op_a[XLEN-1] ? -rs_mag : rs_mag);
    assign div_u   = b_zero ? '1 : op_a / bu_safe;
    assign rem_u   = b_zero ? op_a : op_a % bu_safe;

    logic [XLEN-1:0] alu_res;
    always_comb begin : alu
        alu_res = op_a + op_b;
        case (alu_op)
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_SLL:    alu_res = op_a << shamt;
            ALU_SLT:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_res = {31'd0, op_a < op_b};
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SRL:    alu_res = op_a >> shamt;
            ALU_SRA:    alu_res = $signed(op_a) >>> shamt;
            ALU_OR:     alu_res = op_a | op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_MUL:    alu_res = mul_p[XLEN-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_res = mul_p[2*XLEN-1:XLEN];
            ALU_DIV:    alu_res = div_s;
            ALU_DIVU:   alu_res = div_u;
            ALU_REM:    alu_res = rem_s;
            ALU_REMU:   alu_res = rem_u;
            ALU_FWD:    alu_res = op_b;
            default:    alu_res = op_a + op_b;
        endcase
    end

    // Branch condition compares register values, not the PC/immediate ALU operands
    logic br_taken;
    always_comb begin : branch
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (REG_DATA1 == REG_DATA2);
            3'b001:  br_taken = (REG_DATA1 != REG_DATA2);
            3'b100:  br_taken = ($signed(REG_DATA1) <  $signed(REG_DATA2));
            3'b101:  br_taken = ($signed(REG_DATA1) >= $signed(REG_DATA2));
            3'b110:  br_taken = (REG_DATA1 <  REG_DATA2);
            3'b111:  br_taken = (REG_DATA1 >= REG_DATA2);
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ALU_OUT         <= '0;
            BJ_SIG          <= 1'b0;
            REG_WRITE_EN    <= 1'b0;
            REG_WRITE_ADDR  <= '0;
            DATA_MEM_READ   <= '0;
            DATA_MEM_WRITE  <= '0;
            WB_VALUE_SELECT <= '0;
            STORE_DATA      <= '0;
        end else if (EN) begin
            ALU_OUT         <= is_jalr ? {alu_res[XLEN-1:1], 1'b0} : alu_res;
            BJ_SIG          <= is_jump | (is_branch & br_taken);
            REG_WRITE_EN    <= reg_we;
            REG_WRITE_ADDR  <= INSTRUCTION[11:7];
            DATA_MEM_READ   <= mem_rd;
            DATA_MEM_WRITE  <= mem_wr;
            WB_VALUE_SELECT <= wb_sel;
            STORE_DATA      <= REG_DATA2;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{INSTRUCTION[24:15], mul_p[MULW-1:2*XLEN]};

endmodule

// File: tb/tb_rv32im_decode_execute.sv
// Self-checking bench for rv32im_decode_execute: directed corner cases plus
// randomized instructions checked against an instruction-level reference model.
module tb_rv32im_decode_execute;
    logic        CLK, RESET, EN;
    logic [31:0] INSTRUCTION, PC, REG_DATA1, REG_DATA2, IMMEDIATE;
    logic [2:0]  IMMEDIATE_SELECT;
    logic [31:0] ALU_OUT;
    logic        BJ_SIG, REG_WRITE_EN;
    logic [4:0]  REG_WRITE_ADDR;
    logic [3:0]  DATA_MEM_READ;
    logic [2:0]  DATA_MEM_WRITE;
    logic [1:0]  WB_VALUE_SELECT;
    logic [31:0] STORE_DATA;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011,
                           STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011;

    typedef struct packed {
        logic [31:0] alu;
        logic        bj;
        logic        we;
        logic [4:0]  rd;
        logic [3:0]  mrd;
        logic [2:0]  mwr;
        logic [1:0]  wb;
        logic [31:0] sd;
        logic        chk_alu;
        logic        chk_wb;
    } exp_t;

    rv32im_decode_execute dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .INSTRUCTION(INSTRUCTION), .PC(PC),
        .REG_DATA1(REG_DATA1), .REG_DATA2(REG_DATA2), .IMMEDIATE(IMMEDIATE),
        .IMMEDIATE_SELECT(IMMEDIATE_SELECT), .ALU_OUT(ALU_OUT), .BJ_SIG(BJ_SIG),
        .REG_WRITE_EN(REG_WRITE_EN), .REG_WRITE_ADDR(REG_WRITE_ADDR),
        .DATA_MEM_READ(DATA_MEM_READ), .DATA_MEM_WRITE(DATA_MEM_WRITE),
        .WB_VALUE_SELECT(WB_VALUE_SELECT), .STORE_DATA(STORE_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, rd, op};
    endfunction

    // Base integer operation as defined by the ISA
    function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return alt ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  return (a < b) ? 32'd1 : 32'd0;
            3'b100:  return a ^ b;
            3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    // M-extension in 64-bit arithmetic
    function automatic logic [31:0] muldiv(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa, sb, q;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin if (b == 0) return 32'hFFFF_FFFF; q = sa / sb; return q[31:0]; end
            3'b101: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'b110: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] imm);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '0;
        e.rd = ins[11:7];
        e.sd = r2;
        e.chk_alu = 1'b1;
        case (ins[6:0])
            LUI:    begin e.alu = imm;     e.we = 1; e.wb = 2'b01; e.chk_wb = 1; end
            AUIPC:  begin e.alu = pc + imm; e.we = 1; e.wb = 2'b01; e.chk_wb = 1; end
            JAL:    begin e.alu = pc + imm; e.we = 1; e.bj = 1; e.wb = 2'b00; e.chk_wb = 1; end
            JALR:   begin e.alu = (r1 + imm) & ~32'd1; e.we = 1; e.bj = 1; e.wb = 2'b00; e.chk_wb = 1; end
            BRANCH: begin e.alu = pc + imm; e.bj = taken(f3, r1, r2); end
            LOAD:   begin e.alu = r1 + imm; e.we = 1; e.wb = 2'b10; e.chk_wb = 1; e.mrd = {1'b1, f3}; end
            STORE:  begin e.alu = r1 + imm; e.mwr = {1'b1, f3[1:0]}; end
            OPIMM:  begin e.alu = arith(f3, f3 == 3'b101 && f7[5], r1, imm);
                          e.we = 1; e.wb = 2'b01; e.chk_wb = 1; end
            OP:     begin e.alu = (f7 == 7'b0000001) ? muldiv(f3, r1, r2) : arith(f3, f7[5], r1, r2);
                          e.we = 1; e.wb = 2'b01; e.chk_wb = 1; end
            default: e.chk_alu = 1'b0;
        endcase
        return e;
    endfunction

    // {defined, format} of the immediate for an opcode
    function automatic logic [3:0] isel_exp(input logic [6:0] op);
        case (op)
            LUI, AUIPC:        return 4'b1011;
            JAL:               return 4'b1100;
            JALR, LOAD, OPIMM: return 4'b1000;
            BRANCH:            return 4'b1010;
            STORE:             return 4'b1001;
            default:           return 4'b0000;
        endcase
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm, input logic en);
        @(negedge CLK);
        INSTRUCTION = ins; PC = pc; REG_DATA1 = r1; REG_DATA2 = r2; IMMEDIATE = imm; EN = en;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (ALU_OUT !== 32'd0) begin n_fail++; $display("FAIL reset_alu_out: got %h want 00000000", ALU_OUT); end
        n_checks++;
        if ({BJ_SIG, REG_WRITE_EN} !== 2'b00) begin n_fail++; $display("FAIL reset_bj_we: got %b want 00", {BJ_SIG, REG_WRITE_EN}); end
        n_checks++;
        if ({REG_WRITE_ADDR, DATA_MEM_READ, DATA_MEM_WRITE, WB_VALUE_SELECT, STORE_DATA} !== 46'd0) begin
            n_fail++;
            $display("FAIL reset_other: got %h want 0", {REG_WRITE_ADDR, DATA_MEM_READ, DATA_MEM_WRITE, WB_VALUE_SELECT, STORE_DATA});
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_alu();
        apply(enc(7'h00, 3'b000, 5'd3, OP), 32'h0, 32'd5, 32'd7, 32'h0, 1'b1);
        n_checks++;
        if (ALU_OUT !== 32'd12) begin n_fail++; $display("FAIL add: got %h want 0000000c", ALU_OUT); end
        n_checks++;
        if ({REG_WRITE_EN, WB_VALUE_SELECT, REG_WRITE_ADDR} !== {1'b1, 2'b01, 5'd3}) begin
            n_fail++; $display("FAIL add_ctrl: got %b want 1_01_00011", {REG_WRITE_EN, WB_VALUE_SELECT, REG_WRITE_ADDR});
        end
        apply(enc(7'h20, 3'b000, 5'd3, OP), 32'h0, 32'd5, 32'd7, 32'h0, 1'b1);
        n_checks++;
        if (ALU_OUT !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub: got %h want fffffffe", ALU_OUT); end
        apply(enc(7'h20, 3'b101, 5'd4, OPIMM), 32'h0, 32'h8000_0000, 32'h0, 32'h0000_0404, 1'b1);
        n_checks++;
        if (ALU_OUT !== 32'hF800_0000) begin n_fail++; $display("FAIL srai: got %h want f8000000", ALU_OUT); end
        apply(enc(7'h00, 3'b101, 5'd4, OPIMM), 32'h0, 32'h8000_0000, 32'h0, 32'h0000_0004, 1'b1);
        n_checks++;
        if (ALU_OUT !== 32'h0800_0000) begin n_fail++; $display("FAIL srli: got %h want 08000000", ALU_OUT); end
        apply(enc(7'h00, 3'b010, 5'd5, OP), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1);
        n_checks++;
        if (ALU_OUT !== 32'd1) begin n_fail++; $display("FAIL slt: got %h want 00000001", ALU_OUT); end
        apply(enc(7'h00, 3'b011, 5'd5, OP), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1);
        n_checks++;
        if (ALU_OUT !== 32'd0) begin n_fail++; $display("FAIL sltu: got %h want 00000000", ALU_OUT); end
    endtask

    task automatic test_muldiv();
        apply(enc(7'h01, 3'b001, 5'd6, OP), 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1);
        n_checks++;
        if (ALU_OUT !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh: got %h want 40000000", ALU_OUT); end
        apply(enc(7'h01, 3'b100, 5'd6, OP), 32'h0, 32'd7, 32'd0, 32'h0, 1'b1);
        n_checks++;
        if (ALU_OUT !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_by_zero: got %h want ffffffff", ALU_OUT); end
        apply(enc(7'h01, 3'b110, 5'd6, OP), 32'h0, 32'd7, 32'd0, 32'h0, 1'b1);
        n_checks++;
        if (ALU_OUT !== 32'd7) begin n_fail++; $display("FAIL rem_by_zero: got %h want 00000007", ALU_OUT); end
        apply(enc(7'h01, 3'b100, 5'd6, OP), 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        n_checks++;
        if (ALU_OUT !== 32'h8000_0000) begin n_fail++; $display("FAIL div_overflow: got %h want 80000000", ALU_OUT); end
        apply(enc(7'h01, 3'b110, 5'd6, OP), 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        n_checks++;
        if (ALU_OUT !== 32'd0) begin n_fail++; $display("FAIL rem_overflow: got %h want 00000000", ALU_OUT); end
    endtask

    task automatic test_branch();
        apply(enc(7'h00, 3'b000, 5'd0, BRANCH), 32'h100, 32'd9, 32'd9, 32'd8, 1'b1);
        n_checks++;
        if ({BJ_SIG, ALU_OUT} !== {1'b1, 32'h108}) begin n_fail++; $display("FAIL beq_taken: got %b/%h want 1/00000108", BJ_SIG, ALU_OUT); end
        n_checks++;
        if ({REG_WRITE_EN, IMMEDIATE_SELECT} !== {1'b0, 3'b010}) begin
            n_fail++; $display("FAIL beq_ctrl: got %b want 0_010", {REG_WRITE_EN, IMMEDIATE_SELECT});
        end
        apply(enc(7'h00, 3'b000, 5'd0, BRANCH), 32'h100, 32'd9, 32'd3, 32'd8, 1'b1);
        n_checks++;
        if (BJ_SIG !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: got %b want 0", BJ_SIG); end
        apply(enc(7'h00, 3'b110, 5'd0, BRANCH), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'd8, 1'b1);
        n_checks++;
        if (BJ_SIG !== 1'b0) begin n_fail++; $display("FAIL bltu: got %b want 0", BJ_SIG); end
    endtask

    task automatic test_jump_mem();
        apply(enc(7'h00, 3'b000, 5'd1, JALR), 32'h400, 32'h201, 32'h0, 32'd2, 1'b1);
        n_checks++;
        if ({ALU_OUT, BJ_SIG, WB_VALUE_SELECT, REG_WRITE_EN} !== {32'h202, 1'b1, 2'b00, 1'b1}) begin
            n_fail++; $display("FAIL jalr: got %h/%b/%b/%b want 00000202/1/00/1", ALU_OUT, BJ_SIG, WB_VALUE_SELECT, REG_WRITE_EN);
        end
        apply(enc(7'h00, 3'b010, 5'd7, LOAD), 32'h0, 32'h1000, 32'h0, 32'd4, 1'b1);
        n_checks++;
        if ({DATA_MEM_READ, WB_VALUE_SELECT, ALU_OUT} !== {4'b1010, 2'b10, 32'h1004}) begin
            n_fail++; $display("FAIL lw: got %b/%b/%h want 1010/10/00001004", DATA_MEM_READ, WB_VALUE_SELECT, ALU_OUT);
        end
        apply(enc(7'h00, 3'b000, 5'd0, STORE), 32'h0, 32'h2000, 32'hAB, 32'd1, 1'b1);
        n_checks++;
        if ({DATA_MEM_WRITE, REG_WRITE_EN, STORE_DATA, IMMEDIATE_SELECT} !== {3'b100, 1'b0, 32'hAB, 3'b001}) begin
            n_fail++; $display("FAIL sb: got %b/%b/%h/%b want 100/0/000000ab/001", DATA_MEM_WRITE, REG_WRITE_EN, STORE_DATA, IMMEDIATE_SELECT);
        end
    endtask

    task automatic test_stall();
        apply(enc(7'h00, 3'b000, 5'd3, OP), 32'h0, 32'd5, 32'd7, 32'h0, 1'b1);
        apply(enc(7'h00, 3'b000, 5'd9, JAL), 32'h500, 32'd1, 32'd2, 32'd16, 1'b0);
        n_checks++;
        if ({ALU_OUT, BJ_SIG, REG_WRITE_ADDR, STORE_DATA} !== {32'd12, 1'b0, 5'd3, 32'd7}) begin
            n_fail++; $display("FAIL stall_hold: got %h/%b/%h/%h want 0000000c/0/03/00000007", ALU_OUT, BJ_SIG, REG_WRITE_ADDR, STORE_DATA);
        end
    endtask

    task automatic test_reset_midrun();
        apply(enc(7'h00, 3'b010, 5'd7, LOAD), 32'h0, 32'h1000, 32'h55, 32'd4, 1'b1);
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        n_checks++;
        if ({ALU_OUT, REG_WRITE_EN, REG_WRITE_ADDR, DATA_MEM_READ, WB_VALUE_SELECT, STORE_DATA} !== 76'd0) begin
            n_fail++; $display("FAIL reset_async: got %h/%b/%h/%b/%b/%h want all zero", ALU_OUT, REG_WRITE_EN, REG_WRITE_ADDR, DATA_MEM_READ, WB_VALUE_SELECT, STORE_DATA);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if ({ALU_OUT, BJ_SIG, REG_WRITE_EN, DATA_MEM_READ, STORE_DATA} !== 70'd0) begin
            n_fail++; $display("FAIL reset_hold: got %h/%b/%b/%b/%h want all zero", ALU_OUT, BJ_SIG, REG_WRITE_EN, DATA_MEM_READ, STORE_DATA);
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [6:0] ops [11];
        exp_t held, cur;
        logic [31:0] ins, pc, r1, r2, imm;
        logic [6:0] f7;
        logic [3:0] is_exp;
        logic en;
        ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, 7'b0001111, 7'b1110011};
        held = '0;
        held.chk_alu = 1'b1;
        held.chk_wb  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 10)];
            if (ins[6:0] == OP) begin
                case ($urandom_range(0, 2))
                    0: f7 = 7'h00;
                    1: f7 = 7'h01;
                    default: begin f7 = 7'h20; ins[14:12] = ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b000; end
                endcase
                ins[31:25] = f7;
            end else if (ins[6:0] == OPIMM) begin
                ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            end
            pc  = {$urandom_range(0, 32'hFFFF), 2'b00};
            r1  = pick_val();
            r2  = ($urandom_range(0, 3) == 0) ? r1 : pick_val();
            imm = pick_val();
            en  = ($urandom_range(0, 6) != 0);
            apply(ins, pc, r1, r2, imm, en);
            cur = model(ins, pc, r1, r2, imm);
            if (en) held = cur;
            is_exp = isel_exp(ins[6:0]);
            if (is_exp[3]) begin
                n_checks++;
                if (IMMEDIATE_SELECT !== is_exp[2:0]) begin
                    n_fail++; $display("FAIL rand_isel[%0d]: ins %h got %b want %b", i, ins, IMMEDIATE_SELECT, is_exp[2:0]);
                end
            end
            if (held.chk_alu) begin
                n_checks++;
                if (ALU_OUT !== held.alu) begin
                    n_fail++; $display("FAIL rand_alu[%0d]: ins %h a %h b %h imm %h got %h want %h", i, ins, r1, r2, imm, ALU_OUT, held.alu);
                end
            end
            n_checks++;
            if ({BJ_SIG, REG_WRITE_EN, REG_WRITE_ADDR} !== {held.bj, held.we, held.rd}) begin
                n_fail++; $display("FAIL rand_ctrl[%0d]: ins %h got %b want %b", i, ins, {BJ_SIG, REG_WRITE_EN, REG_WRITE_ADDR}, {held.bj, held.we, held.rd});
            end
            n_checks++;
            if ({DATA_MEM_READ, DATA_MEM_WRITE, STORE_DATA} !== {held.mrd, held.mwr, held.sd}) begin
                n_fail++; $display("FAIL rand_mem[%0d]: ins %h got %b/%b/%h want %b/%b/%h", i, ins, DATA_MEM_READ, DATA_MEM_WRITE, STORE_DATA, held.mrd, held.mwr, held.sd);
            end
            if (held.chk_wb) begin
                n_checks++;
                if (WB_VALUE_SELECT !== held.wb) begin
                    n_fail++; $display("FAIL rand_wb[%0d]: ins %h got %b want %b", i, ins, WB_VALUE_SELECT, held.wb);
                end
            end
        end
    endtask

    initial begin
        RESET = 1'b1; EN = 1'b1;
        INSTRUCTION = 32'h0; PC = 32'h0; REG_DATA1 = 32'h0; REG_DATA2 = 32'h0; IMMEDIATE = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_alu();
        test_muldiv();
        test_branch();
        test_jump_mem();
        test_stall();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
